// File: rtl/srt_iter_core.sv
// srt_iter_core: iteration datapath and control for a radix-4 SRT divider.
// Quotient digit selection is external. Each RUN cycle presents cur_rem and
// cur_div, takes back q_digit, and retires one digit of the recurrence.
// Optional feature: define SRT_OVF_CHECK_EN to enable sticky digit-range
// checking on ovf. Without it, ovf is tied to 0.
module srt_iter_core #(
    parameter int ITER = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [25:0] dividend,
    input  logic [25:0] divisor,
    input  logic [25:0] q_digit,
    output logic [25:0] cur_rem,
    output logic [25:0] cur_div,
    output logic        busy,
    output logic        done,
    output logic [25:0] quotient,
    output logic [25:0] remainder,
    output logic        dz,
    output logic        ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [4:0]  cnt;
    logic [4:0]  cnt_inc;
    logic [25:0] prod;
    logic [25:0] p;
    logic        accept;

    // Recurrence step. Products and differences wrap to 26 bits, so signed
    // digits work with plain unsigned arithmetic.
    assign prod    = q_digit * cur_div;
    assign p       = cur_rem - prod;
    assign cnt_inc = cnt + 5'd1;
    assign accept  = (state == IDLE) && start;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic. A zero divisor goes straight to DONE without any
    // iterations.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (start) state_nxt = (divisor != 26'd0) ? RUN : DONE;
            RUN:  if (cnt_inc == 5'(ITER)) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode.
    always_comb begin
        busy = (state == RUN);
    end

    // Datapath registers. They load on an accepted start, advance on RUN
    // edges, and otherwise hold their values.
    // NOTE: every register here is reset explicitly. There is no memory array,
    // so clearing all state at reset costs nothing.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_rem   <= '0;
            cur_div   <= '0;
            quotient  <= '0;
            remainder <= '0;
            cnt       <= '0;
            dz        <= 1'b0;
        end else if (accept) begin
            cur_rem   <= dividend;
            cur_div   <= divisor;
            quotient  <= '0;
            remainder <= dividend;
            cnt       <= '0;
            dz        <= (divisor == 26'd0);
        end else if (state == RUN) begin
            cur_rem   <= {p[23:0], 2'b00};
            quotient  <= {quotient[23:0], 2'b00} + q_digit;
            remainder <= p;
            cnt       <= cnt_inc;
        end
    end

    // Completion pulse. It is registered from the DONE state, so it rises one
    // edge after the FSM has finished.
    always_ff @(posedge clk) begin
        if (rst) done <= 1'b0;
        else     done <= (state == DONE);
    end

`ifdef SRT_OVF_CHECK_EN
    // Sticky range check: a digit leaving p negative or p >= d is illegal.
    always_ff @(posedge clk) begin
        if (rst)                                               ovf <= 1'b0;
        else if (accept)                                       ovf <= 1'b0;
        else if ((state == RUN) && (p[25] || (p >= cur_div)))  ovf <= 1'b1;
    end
`else
    assign ovf = 1'b0;
`endif

endmodule
